// File: rtl/iq_pkg.sv
// Shared payload layout and helpers for the N-in/M-out issue queue.
// Payload, MSB to LSB: {op[7], brmask, robtag, rd, rs1, rs2, valid, rdy1, rdy2}.
package iq_pkg;

    localparam int OP_W      = 7;
    localparam int RDY2_POS  = 0;
    localparam int RDY1_POS  = 1;
    localparam int VALID_POS = 2;

    function automatic int rs2_lo();
        return 3;
    endfunction

    function automatic int rs1_lo(input int wr);
        return 3 + wr;
    endfunction

    function automatic int rd_lo(input int wr);
        return 3 + 2 * wr;
    endfunction

    function automatic int tag_lo(input int wr);
        return 3 + 3 * wr;
    endfunction

    function automatic int brm_lo(input int wr, input int wt);
        return 3 + 3 * wr + wt;
    endfunction

    function automatic int op_lo(input int wr, input int wt, input int wb);
        return 3 + 3 * wr + wt + wb;
    endfunction

    function automatic int iq_width(input int wr, input int wt, input int wb);
        return op_lo(wr, wt, wb) + OP_W;
    endfunction

    // Destination slot of source k after compaction: the number of
    // surviving sources older than k.
    function automatic int popc_below(input logic [63:0] v, input int n);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < n && v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/iq_select_n.sv
// Oldest-first picker: up to ISSUE_W lowest-index requests, one-hot each.
// Ports: req_i request vector, gnt_o per-lane one-hot grants, vld_o lane valid.
module iq_select_n #(
    parameter int SIZE    = 16,
    parameter int ISSUE_W = 2
) (
    input  logic [SIZE-1:0]               req_i,
    output logic [ISSUE_W-1:0][SIZE-1:0]  gnt_o,
    output logic [ISSUE_W-1:0]            vld_o
);

    logic [SIZE-1:0] rem;

    always_comb begin
        rem = req_i;
        for (int l = 0; l < ISSUE_W; l++) begin
            gnt_o[l] = rem & (~rem + SIZE'(1));
            vld_o[l] = |gnt_o[l];
            rem      = rem & ~gnt_o[l];
        end
    end

endmodule

// File: rtl/issue_queue_nxm.sv
// Compacting age-ordered issue queue: DISPATCH_W in, ISSUE_W out, WAKE_W wakeups.
// Ports: dispatch group + ready, wakeup tags, branch kill, flush, issue lanes, count.
module issue_queue_nxm
    import iq_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int DISPATCH_W = 4,
    parameter int ISSUE_W    = 2,
    parameter int WAKE_W     = 4,
    parameter int WIDTH_REG  = 5,
    parameter int WIDTH_TAG  = 5,
    parameter int WIDTH_BRM  = 3,
    parameter int WIDTH      = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DISPATCH_W*WIDTH-1:0]   i_disp_inst,
    input  logic [DISPATCH_W-1:0]         i_disp_valid,
    output logic                          o_disp_ready,
    input  logic [WAKE_W*WIDTH_REG-1:0]   i_wdest,
    input  logic [WAKE_W-1:0]             i_wdest_valid,
    input  logic [WIDTH_BRM-1:0]          i_brkill,
    input  logic                          i_flush,
    output logic [ISSUE_W*WIDTH-1:0]      o_issue_inst,
    output logic [ISSUE_W-1:0]            o_issue_valid,
    input  logic                          i_issue_ready,
    output logic [$clog2(SIZE+1)-1:0]     o_count
);

    localparam int CW     = $clog2(SIZE + 1);
    localparam int NT     = SIZE + DISPATCH_W;
    localparam int RS2_LO = rs2_lo();
    localparam int RS1_LO = rs1_lo(WIDTH_REG);
    localparam int BRM_LO = brm_lo(WIDTH_REG, WIDTH_TAG);

    logic [WIDTH-1:0]             ent_q [SIZE];
    logic [WIDTH-1:0]             ent_d [SIZE];
    logic [SIZE-1:0]              vld_q, vld_d;
    logic [CW-1:0]                cnt_q, cnt_d;

    logic [SIZE-1:0]              req, kill_e, iss_e;
    logic [ISSUE_W-1:0][SIZE-1:0] gnt;
    logic [ISSUE_W-1:0]           sel_v, iss_v;
    logic [WIDTH-1:0]             src [NT];
    logic [NT-1:0]                keep;
    logic                         acc;
    logic                         r1, r2;
    int                           n;

    assign o_disp_ready = (int'(cnt_q) <= SIZE - DISPATCH_W);
    assign o_count      = cnt_q;
    assign acc          = o_disp_ready & ~i_flush;

    // Requests use registered ready bits only, so a wakeup issues next cycle.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            req[i]    = vld_q[i] & ent_q[i][RDY1_POS] & ent_q[i][RDY2_POS];
            kill_e[i] = vld_q[i] & |(ent_q[i][BRM_LO +: WIDTH_BRM] & i_brkill);
        end
    end

    iq_select_n #(
        .SIZE    (SIZE),
        .ISSUE_W (ISSUE_W)
    ) u_sel (
        .req_i (req),
        .gnt_o (gnt),
        .vld_o (sel_v)
    );

    // Kill and flush mask lanes; a masked lane also drives a zero payload.
    always_comb begin
        iss_e        = '0;
        o_issue_inst = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            iss_v[l] = sel_v[l] & ~i_flush & ~|(gnt[l] & kill_e);
            for (int i = 0; i < SIZE; i++) begin
                if (iss_v[l] && gnt[l][i]) begin
                    o_issue_inst[l*WIDTH +: WIDTH] = ent_q[i];
                end
            end
            if (iss_v[l] && i_issue_ready) iss_e = iss_e | gnt[l];
        end
        o_issue_valid = iss_v;
    end

    // Sources: stored entries first (oldest), then dispatch lanes in order.
    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            src[k]  = ent_q[k];
            keep[k] = vld_q[k] & ~kill_e[k] & ~iss_e[k] & ~i_flush;
        end
        for (int j = 0; j < DISPATCH_W; j++) begin
            src[SIZE+j]  = i_disp_inst[j*WIDTH +: WIDTH];
            keep[SIZE+j] = acc & i_disp_valid[j]
                         & ~|(src[SIZE+j][BRM_LO +: WIDTH_BRM] & i_brkill);
        end
        for (int k = 0; k < NT; k++) begin
            r1 = (src[k][RS1_LO +: WIDTH_REG] == '0);
            r2 = (src[k][RS2_LO +: WIDTH_REG] == '0);
            for (int w = 0; w < WAKE_W; w++) begin
                if (i_wdest_valid[w]) begin
                    if (i_wdest[w*WIDTH_REG +: WIDTH_REG] ==
                        src[k][RS1_LO +: WIDTH_REG]) r1 = 1'b1;
                    if (i_wdest[w*WIDTH_REG +: WIDTH_REG] ==
                        src[k][RS2_LO +: WIDTH_REG]) r2 = 1'b1;
                end
            end
            src[k][RDY1_POS] = src[k][RDY1_POS] | r1;
            src[k][RDY2_POS] = src[k][RDY2_POS] | r2;
        end
    end

    always_comb begin
        n = popc_below(64'(keep), NT);
        for (int d = 0; d < SIZE; d++) begin
            ent_d[d] = '0;
            vld_d[d] = (d < n);
            for (int k = 0; k < NT; k++) begin
                if (keep[k] && popc_below(64'(keep), k) == d) ent_d[d] = src[k];
            end
        end
        cnt_d = CW'(n);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < SIZE; i++) ent_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < SIZE; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: doc/issue_queue_nxm.md
Name: issue_queue_nxm

Overview:
- Parametrised successor to the fixed 4-in/1-out compacting issue queue. Accepts up to DISPATCH_W renamed instructions per cycle, wakes operands from WAKE_W writeback tags, and issues up to ISSUE_W oldest-ready instructions per cycle.
- Supports branch-mask kill, full flush, occupancy count and dispatch backpressure.
- Sits between rename/dispatch and the execution-unit read stage.

Parameters:
- SIZE, 16, number of entries; must be >= DISPATCH_W.
- DISPATCH_W, 4, dispatch lanes per cycle.
- ISSUE_W, 2, issue lanes per cycle.
- WAKE_W, 4, writeback wakeup tags per cycle.
- WIDTH_REG, 5, physical register tag width.
- WIDTH_TAG, 5, ROB tag width.
- WIDTH_BRM, 3, branch mask width.
- WIDTH, 7+WIDTH_BRM+WIDTH_TAG+3*WIDTH_REG+3, payload: {op[7], brmask, robtag, rd, rs1, rs2, valid, rdy1, rdy2}, packed MSB to LSB in that order.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_disp_inst  in  DISPATCH_W*WIDTH  dispatch payloads; lane 0 is oldest.
- i_disp_valid  in  DISPATCH_W  per-lane valid.
- o_disp_ready  out  1  queue accepts a full dispatch group this cycle.
- i_wdest  in  WAKE_W*WIDTH_REG  writeback destination tags.
- i_wdest_valid  in  WAKE_W  per-tag valid.
- i_brkill  in  WIDTH_BRM  mispredicted-branch bit mask; 0 means no kill.
- i_flush  in  1  discard all entries.
- o_issue_inst  out  ISSUE_W*WIDTH  issued payloads; lane 0 is oldest.
- o_issue_valid  out  ISSUE_W  per-lane issue valid.
- i_issue_ready  in  1  downstream accepts all valid issue lanes.
- o_count  out  $clog2(SIZE+1)  occupied entries.

Behaviour:
- Reset:
  - All entry valid bits are 0 and o_count = 0.
  - o_issue_valid = 0 and o_disp_ready = 1.
  - Reset mid-operation discards all state immediately.
- Storage and ordering:
  - Entries are kept age-ordered: index 0 is oldest, occupied entries are contiguous in 0..count-1.
  - Each cycle the queue fully compacts. Survivors (not issued, not killed) shift down with no holes.
  - New entries are appended after the survivors, packed in lane order. Invalid lanes are skipped.
- Dispatch handshake:
  - o_disp_ready = (o_count <= SIZE-DISPATCH_W), computed from registered count only.
  - Dispatch is accepted when o_disp_ready is 1, and is all-or-nothing.
  - Valid lanes presented when o_disp_ready = 0 are ignored; upstream holds them.
- Wakeup:
  - An entry's rdyN bit is set when its rsN equals any valid i_wdest tag.
  - Tag 0 is always treated as ready.
  - Wakeup applies to stored entries and to entries dispatched in the same cycle (bypass).
- Selection:
  - Combinational from registered state. Picks up to ISSUE_W lowest-index entries with valid & rdy1 & rdy2.
  - An entry woken in cycle t is issuable no earlier than t+1.
  - Unused lanes have o_issue_valid = 0 and a zero payload.
- Issue:
  - Selected entries are removed at the clock edge only if i_issue_ready = 1.
  - If i_issue_ready = 0, all entries are retained and the selection repeats.
- Branch kill:
  - Any entry with (brmask & i_brkill) != 0 is removed at the edge. This applies to stored entries and same-cycle dispatch lanes.
  - Kill has priority over issue: o_issue_valid is masked for lanes whose entry is being killed this cycle.
- Flush:
  - i_flush clears all entries at the edge, ignores same-cycle dispatch, and masks o_issue_valid to 0.
- Count:
  - o_count(next) = o_count - issued - killed + accepted_dispatch.
  - The count never exceeds SIZE. Dispatch into a full queue is impossible by construction of o_disp_ready.
- Simultaneous events: issue, kill, wakeup and dispatch all resolve in the same cycle per the priorities above. Priority order is flush > kill > issue > retain.

Decomposition:
- Shared package iq_pkg holds:
  - the payload field offset/width localparams (OP, BRM, TAG, RD, RS1, RS2, VALID, RDY1, RDY2), as functions of WIDTH_REG/WIDTH_TAG/WIDTH_BRM;
  - a compaction-index helper function.
- Sub-module iq_select_n: an oldest-first N-of-SIZE picker taking a request vector and producing ISSUE_W one-hot grant vectors plus per-lane valid. It replaces the single-grant arbiter.

Test Plan:
- Reset, then dispatch 4 valid instructions, all rdy1 = rdy2 = 1, with i_issue_ready = 1 -> next cycle o_count = 4 and o_issue_valid = 2'b11 with lanes 0 and 1. The following cycle o_count = 2 with lanes 2 and 3 issued.
- Fill 16 entries, none ready -> o_count = 16 and o_disp_ready = 0. A dispatch attempt leaves the count unchanged.
- Entry with rs1 = 7, rdy1 = 0 at index 3; drive i_wdest lane 2 = 7 valid -> entry issues exactly one cycle later, never in the same cycle.
- 6 entries with brmask {001,010,001,100,000,011}; i_brkill = 001 -> entries 0, 2 and 5 removed, o_count = 3, and survivors are compacted to indices 0..2 in original order.
- 2 ready entries with i_issue_ready = 0 for 3 cycles -> same payloads held on o_issue_inst and o_count constant. When ready rises, both are removed in one cycle.
- i_flush asserted together with 4 valid dispatch lanes and 5 ready entries -> o_issue_valid = 0 that cycle, and next cycle o_count = 0.
